// File: rtl/strobe_rx_arb_pkg.sv
// Shared constants and elaboration helpers for the toggle-strobe receive arbiter.
package strobe_rx_arb_pkg;

   localparam int STAGES_MIN = 2;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/toggle_sync.sv
// Per-channel toggle synchroniser: a sync chain plus one history flop. A level
// change on the synchronised toggle becomes a one-cycle event once primed.
module toggle_sync
   import strobe_rx_arb_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic primed,
   input  logic toggle_in,
   output logic event_o
);
   localparam int DEPTH = (STAGES < STAGES_MIN) ? STAGES_MIN : STAGES;

   logic [DEPTH-1:0] sync_q, sync_d;
   logic             hist_q, hist_d;

   always_comb begin
      // NOTE: every combinational output is assigned on every path, so no latch is inferred.
      sync_d  = {sync_q[DEPTH-2:0], toggle_in};
      hist_d  = sync_q[DEPTH-1];
      event_o = primed & (sync_q[DEPTH-1] ^ hist_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!reset_n) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end
endmodule

// File: rtl/strobe_rx_arb.sv
// Receives per-channel toggle strobes with payload, holds one pending event per
// channel and presents them round-robin on a valid/ready port with overrun flags.
module strobe_rx_arb
   import strobe_rx_arb_pkg::*;
#(
   parameter  int CHANNELS = 4,
   parameter  int WIDTH    = 8,
   parameter  int STAGES   = 2,
   localparam int CW       = (clog2(CHANNELS) > 1) ? clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [CHANNELS-1:0]       toggle_in,
   input  logic [CHANNELS*WIDTH-1:0] data_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CW-1:0]             out_chan,
   output logic [WIDTH-1:0]          out_data,
   output logic [CHANNELS-1:0]       overrun,
   input  logic                      ovr_clr
);
   localparam int DEPTH     = (STAGES < STAGES_MIN) ? STAGES_MIN : STAGES;
   localparam int PRIME_LEN = DEPTH + 1;
   localparam int PW        = clog2(PRIME_LEN + 1);

   logic [PW-1:0]       prime_cnt_q, prime_cnt_d;
   logic                primed;
   logic [CHANNELS-1:0] evt;
   logic [CHANNELS-1:0] pending_q, pending_d;
   logic [CHANNELS-1:0] overrun_q, overrun_d;
   logic [WIDTH-1:0]    hold_q [CHANNELS];
   logic [WIDTH-1:0]    hold_d [CHANNELS];
   logic [CW-1:0]       last_grant_q, last_grant_d;
   logic [CW-1:0]       grant;
   logic                accept;

   assign primed      = (prime_cnt_q == PW'(PRIME_LEN));
   assign prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + 1'b1;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      toggle_sync #(.STAGES(DEPTH)) u_sync (
         .clk       (clk),
         .reset_n   (reset_n),
         .primed    (primed),
         .toggle_in (toggle_in[c]),
         .event_o   (evt[c])
      );
   end

   // Walk downward so the channel closest after last_grant is the one that sticks.
   always_comb begin
      int            idx;
      logic [CW-1:0] sel;
      idx   = 0;
      sel   = '0;
      grant = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         idx = int'(last_grant_q) + 1 + i;
         if (idx >= CHANNELS) idx = idx - CHANNELS;
         sel = CW'(idx);
         if (pending_q[sel]) grant = sel;
      end
   end

   assign out_valid = |pending_q;
   assign out_chan  = grant;
   assign out_data  = hold_q[grant];
   assign overrun   = overrun_q;
   assign accept    = out_valid & out_ready;

   // A new event always wins over a same-cycle acceptance of the same channel.
   always_comb begin
      pending_d    = pending_q;
      overrun_d    = ovr_clr ? '0 : overrun_q;
      hold_d       = hold_q;
      last_grant_d = last_grant_q;
      if (accept) begin
         pending_d[grant] = 1'b0;
         last_grant_d     = grant;
      end
      for (int c = 0; c < CHANNELS; c++) begin
         if (evt[c]) begin
            if (pending_q[c] && !(accept && int'(grant) == c)) overrun_d[c] = 1'b1;
            pending_d[c] = 1'b1;
            hold_d[c]    = data_in[c*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prime_cnt_q  <= '0;
         pending_q    <= '0;
         overrun_q    <= '0;
         last_grant_q <= CW'(CHANNELS - 1);
         // NOTE: hold is a small flop array, so it is reset with the rest and out_data is never X.
         for (int c = 0; c < CHANNELS; c++) hold_q[c] <= '0;
      end else begin
         prime_cnt_q  <= prime_cnt_d;
         pending_q    <= pending_d;
         overrun_q    <= overrun_d;
         last_grant_q <= last_grant_d;
         hold_q       <= hold_d;
      end
   end
endmodule

// File: tb/tb_strobe_rx_arb.sv
// Self-checking bench: directed scenarios plus random traffic against a
// delay-line and round-robin reference model of the toggle-strobe arbiter.
module tb_strobe_rx_arb;
   localparam int CH = 4;
   localparam int W  = 8;
   localparam int S  = 2;
   localparam int CW = 2;

   logic            clk;
   logic            reset_n;
   logic [CH-1:0]   toggle_in;
   logic [CH*W-1:0] data_in;
   logic            out_valid;
   logic            out_ready;
   logic [CW-1:0]   out_chan;
   logic [W-1:0]    out_data;
   logic [CH-1:0]   overrun;
   logic            ovr_clr;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [CH-1:0] m_pend;
   logic [CH-1:0] m_ovr;
   logic [W-1:0]  m_hold [CH];
   int            m_last;
   logic [CH-1:0] samp_q [$];
   int            cool [CH];

   strobe_rx_arb #(.CHANNELS(CH), .WIDTH(W), .STAGES(S)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .toggle_in (toggle_in),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_chan  (out_chan),
      .out_data  (out_data),
      .overrun   (overrun),
      .ovr_clr   (ovr_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_pend = '0;
      m_ovr  = '0;
      m_last = CH - 1;
      for (int c = 0; c < CH; c++) m_hold[c] = '0;
      samp_q.delete();
   endtask

   function automatic int m_grant();
      for (int k = 1; k <= CH; k++) begin
         if (m_pend[(m_last + k) % CH]) return (m_last + k) % CH;
      end
      return 0;
   endfunction

   // An edge sees an event when two consecutive post-reset samples of a
   // channel's toggle, taken S edges earlier, differ.
   task automatic model_edge();
      logic [CH-1:0] ev;
      logic [CH-1:0] pend0;
      logic          acc;
      int            g;
      samp_q.push_back(toggle_in);
      if (samp_q.size() > S + 2) void'(samp_q.pop_front());
      ev    = (samp_q.size() == S + 2) ? (samp_q[0] ^ samp_q[1]) : '0;
      pend0 = m_pend;
      acc   = (|m_pend) && out_ready;
      g     = m_grant();
      if (acc) begin
         m_pend[g] = 1'b0;
         m_last    = g;
      end
      if (ovr_clr) m_ovr = '0;
      for (int c = 0; c < CH; c++) begin
         if (ev[c]) begin
            if (pend0[c] && !(acc && g == c)) m_ovr[c] = 1'b1;
            m_pend[c] = 1'b1;
            m_hold[c] = data_in[c*W +: W];
         end
      end
   endtask

   task automatic check_model();
      int g;
      check("valid", 32'(out_valid), 32'(|m_pend));
      check("overrun", 32'(overrun), 32'(m_ovr));
      if (|m_pend) begin
         g = m_grant();
         check("chan", 32'(out_chan), 32'(g));
         check("data", 32'(out_data), 32'(m_hold[g]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset_n) model_edge();
      #2;
      check_model();
   endtask

   task automatic flip(input int c, input logic [W-1:0] d);
      toggle_in[c]       = ~toggle_in[c];
      data_in[c*W +: W]  = d;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      m_reset();
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (4) tick();
   endtask

   initial begin
      reset_n   = 1'b1;
      toggle_in = 4'b0101;
      data_in   = '0;
      out_ready = 1'b1;
      ovr_clr   = 1'b0;
      m_reset();
      #1 reset_n = 1'b0;
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      repeat (2) tick();
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_valid", 32'(out_valid), 32'd0);
      end

      // Single event on channel 2, seen S edges after the toggle, for one cycle
      toggle_in = '0;
      do_reset();
      flip(2, 8'hA5);
      tick(); check("lat_k", 32'(out_valid), 32'd0);
      tick(); check("lat_k1", 32'(out_valid), 32'd0);
      tick();
      check("lat_valid", 32'(out_valid), 32'd1);
      check("lat_chan", 32'(out_chan), 32'd2);
      check("lat_data", 32'(out_data), 32'hA5);
      tick(); check("lat_once", 32'(out_valid), 32'd0);

      // All channels at once: round-robin order from a fresh reset, twice
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < CH; c++) flip(c, W'(8'h10 * (r + 1) + c));
         tick(); tick();
         for (int i = 0; i < CH; i++) begin
            tick();
            check("rr_valid", 32'(out_valid), 32'd1);
            check("rr_chan", 32'(out_chan), 32'(i));
            check("rr_data", 32'(out_data), 32'(8'h10 * (r + 1) + i));
         end
         tick(); check("rr_drain", 32'(out_valid), 32'd0);
      end

      // Overrun on channel 1 and its clear
      out_ready = 1'b0;
      flip(1, 8'h11);
      repeat (S + 2) tick();
      check("ovr_first", 32'(out_data), 32'h11);
      flip(1, 8'h22);
      repeat (S + 2) tick();
      check("ovr_flag", 32'(overrun), 32'b0010);
      check("ovr_data", 32'(out_data), 32'h22);
      check("ovr_chan", 32'(out_chan), 32'd1);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      check("ovr_clr", 32'(overrun), 32'd0);
      out_ready = 1'b1;
      tick(); check("ovr_drain", 32'(out_valid), 32'd0);

      // New event on channel 0 in the very cycle it is accepted
      out_ready = 1'b0;
      flip(0, 8'h33);
      repeat (S + 2) tick();
      check("same_first", 32'(out_data), 32'h33);
      flip(0, 8'h44);
      repeat (S) tick();
      out_ready = 1'b1;
      tick();
      check("same_valid", 32'(out_valid), 32'd1);
      check("same_chan", 32'(out_chan), 32'd0);
      check("same_data", 32'(out_data), 32'h44);
      check("same_ovr", 32'(overrun), 32'd0);
      tick(); check("same_drain", 32'(out_valid), 32'd0);

      // Reset while channel 3 is pending
      out_ready = 1'b0;
      flip(3, 8'h77);
      repeat (S + 2) tick();
      check("mid_pend", 32'(out_chan), 32'd3);
      reset_n = 1'b0;
      m_reset();
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_ovr", 32'(overrun), 32'd0);
      repeat (2) tick();
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("mid_after", 32'(out_valid), 32'd0);
      end

      // Random traffic respecting the per-channel hold time
      for (int c = 0; c < CH; c++) cool[c] = 0;
      for (int n = 0; n < 3000; n++) begin
         out_ready = ($urandom_range(0, 9) < 7);
         ovr_clr   = ($urandom_range(0, 39) == 0);
         for (int c = 0; c < CH; c++) begin
            if (cool[c] > 0) cool[c]--;
            else if ($urandom_range(0, 7) == 0) begin
               flip(c, W'($urandom));
               cool[c] = S + 2;
            end
         end
         tick();
      end
      ovr_clr = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
